// File: rtl/serial_frame_source_pkg.sv
// Shared constants for serial_frame_source.
// Holds the state encoding and the default word width used by the
// interface and the top module.
package serial_frame_source_pkg;

  localparam logic ST_IDLE  = 1'b0;
  localparam logic ST_SHIFT = 1'b1;

  localparam int unsigned DEFAULT_WIDTH = 8;

  typedef enum logic {
    StIdle  = ST_IDLE,
    StShift = ST_SHIFT
  } state_e;

endpackage

// File: rtl/serial_frame_source_if.sv
// Load handshake and serial output bundle for serial_frame_source.
//   load_data/load_valid/load_ready : parallel word handshake (upstream -> block)
//   sout/sout_valid                 : serial bit stream and data-vs-idle flag
//   frame_start/frame_last          : high while first/last bit of a word is on sout
// master = upstream word producer, slave = serial_frame_source.
interface serial_frame_source_if #(
  parameter int unsigned WIDTH = serial_frame_source_pkg::DEFAULT_WIDTH
);

  logic [WIDTH-1:0] load_data;
  logic             load_valid;
  logic             load_ready;
  logic             sout;
  logic             sout_valid;
  logic             frame_start;
  logic             frame_last;

  modport master (
    output load_data, load_valid,
    input  load_ready, sout, sout_valid, frame_start, frame_last
  );

  modport slave (
    input  load_data, load_valid,
    output load_ready, sout, sout_valid, frame_start, frame_last
  );

endinterface

// File: rtl/serial_frame_source.sv
// Parallel-to-serial word source feeding a single-bit sequence detector.
// Words arrive on a valid/ready handshake and leave one bit per clock on sout.
// A one-word holding buffer lets consecutive words stream with no idle cycle.
// Ports:
//   clk : system clock, rising edge
//   clr : synchronous active-low reset
//   bus : serial_frame_source_if slave modport (handshake + serial outputs)
// All outputs are registered except load_ready.
module serial_frame_source
  import serial_frame_source_pkg::*;
#(
  parameter int unsigned WIDTH     = DEFAULT_WIDTH,
  parameter bit          MSB_FIRST = 1'b1,
  parameter bit          IDLE_BIT  = 1'b0
) (
  input logic                  clk,
  input logic                  clr,
  serial_frame_source_if.slave bus
);

  localparam int unsigned CntW = $clog2(WIDTH);
  localparam logic [CntW-1:0] LastCnt = CntW'(WIDTH - 1);

  state_e           state_q, state_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic [WIDTH-1:0] shift_q, shift_d;
  logic [WIDTH-1:0] hold_q, hold_d;
  logic             hold_full_q, hold_full_d;
  logic             sout_q, sout_d;
  logic             sout_valid_q, sout_valid_d;
  logic             frame_start_q, frame_start_d;
  logic             frame_last_q, frame_last_d;

  logic             load_ready;
  logic             accept;
  logic             load_en;
  logic             advance;
  logic [WIDTH-1:0] load_word;
  logic [WIDTH-1:0] src;

  assign load_ready = clr & ~hold_full_q;
  assign accept     = bus.load_valid & load_ready;

  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    shift_d       = shift_q;
    hold_d        = hold_q;
    hold_full_d   = hold_full_q;
    sout_d        = sout_q;
    sout_valid_d  = sout_valid_q;
    frame_start_d = 1'b0;
    frame_last_d  = 1'b0;
    load_en       = 1'b0;
    advance       = 1'b0;
    load_word     = bus.load_data;

    unique case (state_q)
      StIdle: begin
        if (accept) load_en = 1'b1;
      end
      StShift: begin
        if (cnt_q == LastCnt) begin
          // End of word: held word wins over a fresh handshake.
          if (hold_full_q) begin
            load_en     = 1'b1;
            load_word   = hold_q;
            hold_full_d = 1'b0;
          end else if (accept) begin
            load_en = 1'b1;
          end
        end else begin
          advance = 1'b1;
          if (accept) begin
            hold_d      = bus.load_data;
            hold_full_d = 1'b1;
          end
        end
      end
      default: ;
    endcase

    // shift_q only ever holds the bits not yet presented on sout.
    src = load_en ? load_word : shift_q;

    if (load_en || advance) begin
      state_d       = StShift;
      cnt_d         = load_en ? '0 : cnt_q + CntW'(1);
      sout_d        = MSB_FIRST ? src[WIDTH-1] : src[0];
      shift_d       = MSB_FIRST ? {src[WIDTH-2:0], 1'b0} : {1'b0, src[WIDTH-1:1]};
      sout_valid_d  = 1'b1;
      frame_start_d = load_en;
      frame_last_d  = (cnt_d == LastCnt);
    end else begin
      state_d      = StIdle;
      cnt_d        = '0;
      sout_d       = IDLE_BIT;
      sout_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!clr) begin
      state_q       <= StIdle;
      cnt_q         <= '0;
      shift_q       <= '0;
      hold_q        <= '0;
      hold_full_q   <= 1'b0;
      sout_q        <= IDLE_BIT;
      sout_valid_q  <= 1'b0;
      frame_start_q <= 1'b0;
      frame_last_q  <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      shift_q       <= shift_d;
      hold_q        <= hold_d;
      hold_full_q   <= hold_full_d;
      sout_q        <= sout_d;
      sout_valid_q  <= sout_valid_d;
      frame_start_q <= frame_start_d;
      frame_last_q  <= frame_last_d;
    end
  end

  assign bus.load_ready  = load_ready;
  assign bus.sout        = sout_q;
  assign bus.sout_valid  = sout_valid_q;
  assign bus.frame_start = frame_start_q;
  assign bus.frame_last  = frame_last_q;

endmodule

// File: tb/tb_serial_frame_source.sv
// Directed bench for serial_frame_source.
// Three instances: WIDTH=4 MSB-first, WIDTH=4 LSB-first, WIDTH=2 MSB-first.
// Per-cycle observations are packed as {sout, sout_valid, frame_start, frame_last, load_ready}.
// A small overlapping 1010 detector watches the MSB-first sout, standing in for the
// downstream detector.
module tb_serial_frame_source;

  logic clk;
  logic clr;

  int unsigned n_vec;
  int unsigned n_err;

  serial_frame_source_if #(.WIDTH(4)) bus_m ();
  serial_frame_source_if #(.WIDTH(4)) bus_l ();
  serial_frame_source_if #(.WIDTH(2)) bus_w2 ();

  serial_frame_source #(.WIDTH(4), .MSB_FIRST(1'b1), .IDLE_BIT(1'b0)) u_dut_m (
    .clk (clk),
    .clr (clr),
    .bus (bus_m)
  );

  serial_frame_source #(.WIDTH(4), .MSB_FIRST(1'b0), .IDLE_BIT(1'b0)) u_dut_l (
    .clk (clk),
    .clr (clr),
    .bus (bus_l)
  );

  serial_frame_source #(.WIDTH(2), .MSB_FIRST(1'b1), .IDLE_BIT(1'b0)) u_dut_w2 (
    .clk (clk),
    .clr (clr),
    .bus (bus_w2)
  );

  logic [4:0] obs_m, obs_l, obs_w2;
  assign obs_m  = {bus_m.sout, bus_m.sout_valid, bus_m.frame_start, bus_m.frame_last,
                   bus_m.load_ready};
  assign obs_l  = {bus_l.sout, bus_l.sout_valid, bus_l.frame_start, bus_l.frame_last,
                   bus_l.load_ready};
  assign obs_w2 = {bus_w2.sout, bus_w2.sout_valid, bus_w2.frame_start, bus_w2.frame_last,
                   bus_w2.load_ready};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Overlapping 1010 detector fed with every cycle's sout, idle level included.
  logic [2:0]  hist = 3'b000;
  int unsigned hits = 0;
  always @(negedge clk) begin
    if ({hist, bus_m.sout} == 4'b1010) hits++;
    hist = {hist[1:0], bus_m.sout};
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0b expected %0b", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic drv_m(input logic v, input logic [3:0] d);
    bus_m.load_valid = v;
    bus_m.load_data  = d;
    tick();
  endtask

  task automatic drv_l(input logic v, input logic [3:0] d);
    bus_l.load_valid = v;
    bus_l.load_data  = d;
    tick();
  endtask

  task automatic drv_w2(input logic v, input logic [1:0] d);
    bus_w2.load_valid = v;
    bus_w2.load_data  = d;
    tick();
  endtask

  int unsigned base;

  initial begin
    n_vec = 0;
    n_err = 0;
    bus_m.load_valid  = 1'b0;
    bus_m.load_data   = 4'b0000;
    bus_l.load_valid  = 1'b0;
    bus_l.load_data   = 4'b0000;
    bus_w2.load_valid = 1'b0;
    bus_w2.load_data  = 2'b00;

    // Reset with a handshake offered during reset: it must be ignored.
    clr = 1'b0;
    drv_m(1'b1, 4'b1010);
    drv_m(1'b1, 4'b1010);
    check("rst_state", obs_m, 5'b00000);
    check("rst_state_lsb", obs_l, 5'b00000);
    clr = 1'b1;
    drv_m(1'b0, 4'b0000);
    check("rst_release_idle", obs_m, 5'b00001);
    drv_m(1'b0, 4'b0000);
    check("rst_no_late_accept", obs_m, 5'b00001);

    // 1: single word 1010 into idle block.
    base = hits;
    drv_m(1'b1, 4'b1010); check("t1_c1", obs_m, 5'b11101);
    drv_m(1'b0, 4'b0000); check("t1_c2", obs_m, 5'b01001);
    drv_m(1'b0, 4'b0000); check("t1_c3", obs_m, 5'b11001);
    drv_m(1'b0, 4'b0000); check("t1_c4", obs_m, 5'b01011);
    drv_m(1'b0, 4'b0000); check("t1_c5", obs_m, 5'b00001);
    drv_m(1'b0, 4'b0000);
    check("t1_detect", hits - base, 1);

    // 2: back-to-back 1010, 1010 through the holding buffer.
    base = hits;
    drv_m(1'b1, 4'b1010); check("t2_c1", obs_m, 5'b11101);
    drv_m(1'b1, 4'b1010); check("t2_c2", obs_m, 5'b01000);
    drv_m(1'b0, 4'b0000); check("t2_c3", obs_m, 5'b11000);
    drv_m(1'b0, 4'b0000); check("t2_c4", obs_m, 5'b01010);
    drv_m(1'b0, 4'b0000); check("t2_c5", obs_m, 5'b11101);
    drv_m(1'b0, 4'b0000); check("t2_c6", obs_m, 5'b01001);
    drv_m(1'b0, 4'b0000); check("t2_c7", obs_m, 5'b11001);
    drv_m(1'b0, 4'b0000); check("t2_c8", obs_m, 5'b01011);
    drv_m(1'b0, 4'b0000); check("t2_c9", obs_m, 5'b00001);
    drv_m(1'b0, 4'b0000);
    check("t2_detect", hits - base, 3);

    // 3: LSB-first 0101 gives the same stream as scenario 1.
    drv_l(1'b1, 4'b0101); check("t3_c1", obs_l, 5'b11101);
    drv_l(1'b0, 4'b0000); check("t3_c2", obs_l, 5'b01001);
    drv_l(1'b0, 4'b0000); check("t3_c3", obs_l, 5'b11001);
    drv_l(1'b0, 4'b0000); check("t3_c4", obs_l, 5'b01011);
    drv_l(1'b0, 4'b0000); check("t3_c5", obs_l, 5'b00001);

    // 4: handshake exactly at the last-bit edge with hold empty.
    drv_m(1'b1, 4'b1010); check("t4_a1", obs_m, 5'b11101);
    drv_m(1'b0, 4'b0000); check("t4_a2", obs_m, 5'b01001);
    drv_m(1'b0, 4'b0000); check("t4_a3", obs_m, 5'b11001);
    drv_m(1'b0, 4'b0000); check("t4_a4", obs_m, 5'b01011);
    drv_m(1'b1, 4'b1110); check("t4_b1", obs_m, 5'b11101);
    drv_m(1'b0, 4'b0000); check("t4_b2", obs_m, 5'b11001);
    drv_m(1'b0, 4'b0000); check("t4_b3", obs_m, 5'b11001);
    drv_m(1'b0, 4'b0000); check("t4_b4", obs_m, 5'b01011);
    drv_m(1'b0, 4'b0000); check("t4_idle", obs_m, 5'b00001);

    // 5: hold full, load_valid held three extra cycles with 0011.
    drv_m(1'b1, 4'b1010); check("t5_a1", obs_m, 5'b11101);
    drv_m(1'b1, 4'b0011); check("t5_a2", obs_m, 5'b01000);
    drv_m(1'b1, 4'b0011); check("t5_a3", obs_m, 5'b11000);
    drv_m(1'b1, 4'b0011); check("t5_a4", obs_m, 5'b01010);
    drv_m(1'b1, 4'b0011); check("t5_b1", obs_m, 5'b01101);
    drv_m(1'b0, 4'b0000); check("t5_b2", obs_m, 5'b01001);
    drv_m(1'b0, 4'b0000); check("t5_b3", obs_m, 5'b11001);
    drv_m(1'b0, 4'b0000); check("t5_b4", obs_m, 5'b11011);
    drv_m(1'b0, 4'b0000); check("t5_once", obs_m, 5'b00001);

    // WIDTH=2 back-to-back: 10 then 01.
    drv_w2(1'b1, 2'b10); check("w2_c1", obs_w2, 5'b11101);
    drv_w2(1'b1, 2'b01); check("w2_c2", obs_w2, 5'b01010);
    drv_w2(1'b0, 2'b00); check("w2_c3", obs_w2, 5'b01101);
    drv_w2(1'b0, 2'b00); check("w2_c4", obs_w2, 5'b11011);
    drv_w2(1'b0, 2'b00); check("w2_c5", obs_w2, 5'b00001);

    // 6: reset during bit 2 with a word held; neither word may appear afterwards.
    drv_m(1'b1, 4'b1010); check("t6_a1", obs_m, 5'b11101);
    drv_m(1'b1, 4'b0011); check("t6_a2", obs_m, 5'b01000);
    bus_m.load_valid = 1'b0;
    clr = 1'b0;
    #1;
    check("t6_ready_in_clr", bus_m.load_ready, 1'b0);
    tick();
    check("t6_cleared", obs_m, 5'b00000);
    clr = 1'b1;
    for (int i = 0; i < 6; i++) begin
      tick();
      check($sformatf("t6_idle%0d", i), obs_m, 5'b00001);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/serial_frame_source.md
Name: serial_frame_source

Overview:
- Upstream stage that feeds the single-bit `in` input of the serial sequence detectors (e.g. the 1010 detector).
- Accepts parallel words over a valid/ready handshake and shifts them out one bit per clock on `sout`.
- Frame markers are provided for alignment and debug.
- A one-word holding buffer allows consecutive words to stream back-to-back with no idle cycle, so overlapping patterns across word boundaries reach the detector intact.

Parameters:
- WIDTH, 8, bits per word; legal range 2..32.
- MSB_FIRST, 1: 1 = bit WIDTH-1 is sent first; 0 = bit 0 is sent first.
- IDLE_BIT, 0, level driven on `sout` when no word is being shifted.

Ports:
- clk  input  1  single system clock; all state changes on the rising edge.
- clr  input  1  synchronous, active-low reset; sampled on the rising edge of clk.
- load_data  input  WIDTH  parallel word to serialize.
- load_valid  input  1  load_data is valid.
- load_ready  output  1  block can accept a word this cycle.
- sout  output  1  serial bit stream; connects to the detector `in`.
- sout_valid  output  1  sout carries a data bit, not the idle level.
- frame_start  output  1  high while the first bit of a word is on sout.
- frame_last  output  1  high while the last bit of a word is on sout.

Behaviour:
- Reset (clr low at an edge):
  - Next state is IDLE; holding buffer is emptied; bit counter is 0.
  - sout=IDLE_BIT; sout_valid, frame_start and frame_last are 0.
  - load_ready is 0 in every cycle clr is low.
  - A word in flight and any held word are discarded.
  - A handshake in the reset cycle is ignored.
- State machine: IDLE and SHIFT. All outputs are registered except load_ready.
- load_ready = clr & ~hold_full, combinational from registered state.
- A word is accepted at an edge where load_valid & load_ready.
- Accept in IDLE:
  - The word goes directly to the shift register; state moves to SHIFT.
  - The first bit is on sout in the cycle right after the accepting edge (latency 1).
  - frame_start=1 in that cycle.
- Accept in SHIFT: the word goes to the holding buffer; hold_full=1, so load_ready=0 until the buffer is drained.
- SHIFT:
  - Each bit is held for exactly one cycle; the bit counter counts 0..WIDTH-1.
  - sout_valid=1 throughout.
  - frame_last=1 when counter=WIDTH-1.
- End of word (the edge that ends the last bit), resolved in priority order:
  - Hold full: the held word moves to the shift register and hold empties. The next cycle shows its first bit with frame_start=1 and no gap.
  - Hold empty and a handshake occurs at this edge: the new word loads directly into the shift register, with no gap.
  - Otherwise: state returns to IDLE; the next cycle drives sout=IDLE_BIT and sout_valid=0.
- Stalls: load_valid held high while load_ready=0 causes no acceptance. The upstream keeps data stable; nothing is lost or duplicated.
- Changes to load_data while not accepted have no effect.
- WIDTH=2 streams correctly back-to-back. frame_start and frame_last are never high in the same cycle for WIDTH≥2.

Decomposition:
- Shared state-machine package:
  - state encoding constants: ST_IDLE=1'b0, ST_SHIFT=1'b1;
  - default word-width constant (8).
- The bit counter width is $clog2(WIDTH), computed locally.
- No sub-module: the shift register, holding buffer and counter stay inline in a single module of about 150 lines.
- The bench instantiates this block driving the existing 1010 detector for integration checks.

Test Plan:
1. WIDTH=4, MSB_FIRST=1, one load of 4'b1010 into an idle block -> sout=1,0,1,0 in cycles 1-4 after acceptance; frame_start in cycle 1; frame_last in cycle 4; cycle 5 sout=0 with sout_valid=0. With the detector chained, its out asserts per the detector spec.
2. Back-to-back: load 4'b1010, then 4'b1010 one cycle later -> second word is accepted into hold and load_ready drops. Eight contiguous bits 10101010 follow with no idle cycle; load_ready returns to 1 the cycle after the first word's last bit.
3. MSB_FIRST=0, load 4'b0101 -> sout=1,0,1,0, identical to scenario 1.
4. Handshake exactly at a last-bit edge with hold empty (load 4'b1110) -> next word's first bit appears the following cycle, no gap; frame_start=1.
5. Hold full with load_valid held for 3 extra cycles, data 4'b0011 -> no acceptance while load_ready=0; 0011 is accepted once and sent once.
6. clr driven low during bit 2 of a word, with a word also held -> next cycle sout=0, sout_valid=0, load_ready=0. After clr returns high: block is IDLE with load_ready=1, and neither old word is ever emitted.
